// File: rtl/integrador_pkg.sv
// Constants shared by the integrator and differentiator stages of the control datapath.
package integrador_pkg;
    localparam int W    = 19;
    localparam int FRAC = 8;
    localparam logic signed [W-1:0] K_DEF    = 19'sd150;
    localparam logic signed [W-1:0] RAIL_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] RAIL_MIN = {1'b1, {(W-1){1'b0}}};
endpackage

// File: rtl/integrador_if.sv
// Sample/control inputs and integrator outputs of the integrador block.
import integrador_pkg::*;

interface integrador_if;
    logic                enable;
    logic                hold;
    logic                clear;
    logic signed [W-1:0] e;
    logic signed [W-1:0] ik;
    logic                valid;
    logic                sat;

    modport master (output enable, hold, clear, e, input ik, valid, sat);
    modport slave  (input enable, hold, clear, e, output ik, valid, sat);
endinterface

// File: rtl/integrador_sumador_saturado.sv
// Signed adder that clips a WI-bit sum to the WO-bit two's complement rails.
module sumador_saturado #(
    parameter int WI = 19,
    parameter int WO = 19
) (
    input  logic signed [WI-1:0] a,
    input  logic signed [WI-1:0] b,
    output logic signed [WO-1:0] sum,
    output logic                 flag
);
    localparam logic signed [WI:0] HI = {{(WI-WO+2){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WI:0] LO = ~HI;

    logic signed [WI:0] full;

    assign full = $signed({a[WI-1], a}) + $signed({b[WI-1], b});

    always_comb begin
        sum  = full[WO-1:0];
        flag = 1'b0;
        if (full > HI) begin
            sum  = HI[WO-1:0];
            flag = 1'b1;
        end else if (full < LO) begin
            sum  = LO[WO-1:0];
            flag = 1'b1;
        end
    end
endmodule

// File: rtl/integrador.sv
// Two-stage saturating integrator: stage 1 scales e by K, stage 2 accumulates into ik.
import integrador_pkg::*;

module integrador #(
    parameter logic signed [W-1:0] K = K_DEF
) (
    input logic          clk,
    input logic          rst_n,
    integrador_if.slave  bus
);
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] q;
    logic signed [W-1:0]   s1_next;
    logic                  clip1_unused;
    logic signed [W-1:0]   acc_sum;
    logic                  acc_flag;

    logic signed [W-1:0]   s1;
    logic                  v1;
    logic signed [W-1:0]   ik_q;
    logic                  valid_q;
    logic                  sat_q;

    // Operands widen to 2W before the multiply, so the full product is kept.
    assign p = K * bus.e;
    assign q = p >>> FRAC;

    sumador_saturado #(.WI(2*W), .WO(W)) u_clip (
        .a    (q),
        .b    ('0),
        .sum  (s1_next),
        .flag (clip1_unused)
    );

    sumador_saturado #(.WI(W), .WO(W)) u_acc (
        .a    (ik_q),
        .b    (s1),
        .sum  (acc_sum),
        .flag (acc_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            v1      <= 1'b0;
            ik_q    <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (bus.clear) begin
            s1      <= '0;
            v1      <= 1'b0;
            ik_q    <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            v1      <= bus.enable;
            if (bus.enable) s1 <= s1_next;
            // A held sample still reports Valid, but leaves ik and Sat alone.
            valid_q <= v1;
            if (v1 && !bus.hold) begin
                ik_q  <= acc_sum;
                sat_q <= acc_flag;
            end
        end
    end

    assign bus.ik    = ik_q;
    assign bus.valid = valid_q;
    assign bus.sat   = sat_q;
endmodule

// File: tb/tb_integrador.sv
// Directed self-checking bench for the integrador saturating integrator.
import integrador_pkg::*;

module tb_integrador;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    integrador_if bus ();

    integrador dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int exp_ik, input int exp_valid, input int exp_sat);
        chk({tag, ".ik"},    32'(bus.ik),    exp_ik);
        chk({tag, ".valid"}, 32'(bus.valid), exp_valid);
        chk({tag, ".sat"},   32'(bus.sat),   exp_sat);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.hold   = 1'b0;
        bus.clear  = 1'b0;
        bus.e      = '0;
        #12;
        chk_out("reset", 0, 0, 0);
        rst_n = 1'b1;

        // 1: single sample, two-edge latency
        bus.e = 19'sd256; bus.enable = 1'b1;
        tick();
        chk_out("t1_edge1", 0, 0, 0);
        bus.enable = 1'b0;
        tick();
        chk_out("t1_edge2", 150, 1, 0);
        tick();
        chk_out("t1_after", 150, 0, 0);

        // 2: ten back-to-back samples
        do_clear();
        chk_out("t2_clear", 0, 0, 0);
        bus.e = 19'sd256; bus.enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k > 1) chk_out($sformatf("t2_step%0d", k - 1), 150 * (k - 1), 1, 0);
        end
        bus.enable = 1'b0;
        tick();
        chk_out("t2_step10", 1500, 1, 0);
        tick();
        chk("t2_valid_end", 32'(bus.valid), 0);

        // 3: negative input and floor rounding
        do_clear();
        bus.e = -19'sd256; bus.enable = 1'b1;
        tick();
        bus.e = 19'sd1;
        tick();
        chk_out("t3_neg", -150, 1, 0);
        bus.e = -19'sd1;
        tick();
        chk_out("t3_plus1", -150, 1, 0);
        bus.enable = 1'b0;
        tick();
        chk_out("t3_minus1", -151, 1, 0);

        // 4: climb into the positive rail, then come off it
        do_clear();
        bus.e = 19'sd262143; bus.enable = 1'b1;
        tick();
        tick();
        chk_out("t4_first", 153599, 1, 0);
        tick();
        chk_out("t4_clip", 262143, 1, 1);
        bus.e = -19'sd256;
        tick();
        chk_out("t4_hold_rail", 262143, 1, 1);
        bus.enable = 1'b0;
        tick();
        chk_out("t4_off_rail", 261993, 1, 0);

        // 5: anti-windup hold while saturated
        bus.e = 19'sd262143; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        chk_out("t5_sat", 262143, 1, 1);
        bus.e = -19'sd25600; bus.enable = 1'b1; bus.hold = 1'b1;
        tick();
        chk_out("t5_hold_a", 262143, 0, 1);
        tick();
        chk_out("t5_hold_b", 262143, 1, 1);
        tick();
        chk_out("t5_hold_c", 262143, 1, 1);
        bus.enable = 1'b0;
        tick();
        chk_out("t5_hold_d", 262143, 1, 1);
        bus.hold = 1'b0; bus.enable = 1'b1;
        tick();
        chk_out("t5_rel_e", 262143, 0, 1);
        bus.enable = 1'b0;
        tick();
        chk_out("t5_rel_f", 247143, 1, 0);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        chk_out("t5_rel_g", 232143, 1, 0);

        // 6: clear drops in-flight samples; clear beats enable; async reset
        bus.e = 19'sd256; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0; bus.clear = 1'b1;
        tick();
        chk_out("t6_clear", 0, 0, 0);
        bus.clear = 1'b0;
        tick();
        chk_out("t6_dropped", 0, 0, 0);
        bus.enable = 1'b1; bus.clear = 1'b1;
        tick();
        bus.enable = 1'b0; bus.clear = 1'b0;
        tick();
        chk_out("t6_clr_wins", 0, 0, 0);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        chk_out("t6_pre_rst", 150, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t6_async_rst", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick();
        chk_out("t6_post_rst", 150, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
